program_counter: RTL and testbench
==================================

// Module: program_counter
//
// PURPOSE
//   Program counter register for the single-cycle CPU. Holds the address of
//   the instruction currently being fetched and drives it to instruction
//   memory and the next-PC logic. Each clock it loads the next-PC value from
//   the next-PC mux. A synchronous active-low reset forces it to the reset
//   vector.
//
// PARAMETERS
//   WIDTH         32            address width in bits
//   RESET_VECTOR  32'h00000000  value loaded while reset is asserted
//
// PORTS
//   clk           in   1      clock; all state updates on the rising edge
//   startin       in   1      synchronous reset, active-low (0 = reset)
//   in            in   WIDTH  next-PC value from the next-PC mux
//   out           out  WIDTH  current PC, registered
//   out_plus4     out  WIDTH  out + 4, combinational, modulo 2^WIDTH
//   misaligned    out  1      combinational: out[1:0] != 2'b00
//   valid         out  1      registered: 0 during reset, 1 once a load has
//                             occurred
//
// BEHAVIOUR
//   - One clock domain. Reset is synchronous and active-low:
//       * startin is sampled only at the rising edge of clk.
//       * It has no asynchronous effect.
//   - Rising edge with startin == 0 (reset):
//       * out <= RESET_VECTOR
//       * valid <= 0
//       * in is ignored.
//   - Rising edge with startin == 1 (load):
//       * out <= in
//       * valid <= 1
//   - Latency: a value on in appears on out exactly one rising edge later.
//   - out holds its value between rising edges. There is no enable and no
//     stall; every non-reset edge loads.
//   - Reset wins over load on the same edge. Asserting reset mid-operation
//     returns out to RESET_VECTOR at the next edge.
//   - Reset deassertion: the first edge with startin == 1 loads in. There
//     is no extra idle cycle.
//   - out_plus4 wraps modulo 2^WIDTH (32'hFFFFFFFC -> 32'h00000000). No
//     carry out.
//   - misaligned:
//       * A status flag only; it does not block the load.
//       * It follows out combinationally.
//   - Before the first edge that samples startin, out and valid are
//     undefined. Benches must apply reset first.
//   - No X-propagation masking: an X on in loads X into out.
//
// TESTING
//   1. Reset: startin=0, in=32'd5 for 2 edges -> out=0, valid=0,
//      out_plus4=4, misaligned=0.
//   2. Release and sequence: startin=1, in=1,2,3,4 on successive edges ->
//      out=1,2,3,4, each one edge after in; valid=1 after the first edge.
//   3. Hold between edges: change in between edges -> out unchanged until
//      the next rising edge.
//   4. Mid-run reset: out=32'h40, then startin=0 with in=32'h44 for one
//      edge -> out=0, valid=0; startin=1, in=32'h8 -> out=8 next edge.
//   5. Flags: in=32'h3 loaded -> misaligned=1. in=32'hFFFFFFFC loaded ->
//      out_plus4=0, misaligned=0.
//   6. Async check: toggle startin low/high between edges -> out unaffected.

Source files
------------

// File: rtl/program_counter.sv
// Program counter register for the single-cycle CPU: loads the next-PC value every clock,
// with a synchronous active-low reset to the reset vector.
module program_counter #(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             startin,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_plus4,
    output logic             misaligned,
    output logic             valid
);

    logic [WIDTH-1:0] pc_q;
    logic             valid_q;

    // No enable or stall: every edge out of reset loads the next-PC value.
    always_ff @(posedge clk) begin
        if (!startin) begin
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= in;
            valid_q <= 1'b1;
        end
    end

    always_comb begin
        out        = pc_q;
        valid      = valid_q;
        out_plus4  = pc_q + WIDTH'(4);
        misaligned = (pc_q[1:0] != 2'b00);
    end

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed vector table, between-edge hold/reset sequences, and
// randomized traffic checked against a behavioural model.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        startin;
    logic [31:0] in;
    logic [31:0] out;
    logic [31:0] out_plus4;
    logic        misaligned;
    logic        valid;

    int n_vec  = 0;
    int n_fail = 0;

    program_counter #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .startin    (startin),
        .in         (in),
        .out        (out),
        .out_plus4  (out_plus4),
        .misaligned (misaligned),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [31:0] din;
        logic [31:0] exp_out;
        logic        exp_valid;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Checks all outputs against an expected PC and valid; derived flags come from arithmetic.
    task automatic check_all(input string tag, input logic [31:0] pc, input logic v);
        logic [32:0] sum;
        sum = {1'b0, pc} + 33'd4;
        check({tag, ".out"}, out, pc);
        check({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
        check({tag, ".out_plus4"}, out_plus4, sum[31:0]);
        check({tag, ".misaligned"}, {31'b0, misaligned}, {31'b0, (pc % 4) != 0});
    endtask

    task automatic step(input logic st, input logic [31:0] d);
        @(negedge clk);
        startin = st;
        in      = d;
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[$];
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] r;

    initial begin
        startin = 1'b0;
        in      = '0;

        vecs = '{
            '{1'b0, 32'd5,          32'd0,          1'b0},
            '{1'b0, 32'd5,          32'd0,          1'b0},
            '{1'b1, 32'd1,          32'd1,          1'b1},
            '{1'b1, 32'd2,          32'd2,          1'b1},
            '{1'b1, 32'd3,          32'd3,          1'b1},
            '{1'b1, 32'd4,          32'd4,          1'b1},
            '{1'b1, 32'h40,         32'h40,         1'b1},
            '{1'b0, 32'h44,         32'd0,          1'b0},
            '{1'b1, 32'h8,          32'h8,          1'b1},
            '{1'b1, 32'h3,          32'h3,          1'b1},
            '{1'b1, 32'hFFFF_FFFC,  32'hFFFF_FFFC,  1'b1},
            '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1}
        };

        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid);
        end
        check("wrap.plus4_zero", out_plus4 - 32'd3, 32'd0);

        // Hold between edges: in changes after the edge must not reach out.
        step(1'b1, 32'h0000_1000);
        in = 32'h0000_2222;
        #3;
        check_all("hold.mid", 32'h0000_1000, 1'b1);
        @(posedge clk);
        #1;
        check_all("hold.next", 32'h0000_2222, 1'b1);

        // Reset pulse entirely between edges has no effect.
        @(negedge clk);
        in      = 32'h0000_3000;
        startin = 1'b0;
        #1;
        check_all("async.low", 32'h0000_2222, 1'b1);
        startin = 1'b1;
        #1;
        check_all("async.high", 32'h0000_2222, 1'b1);
        @(posedge clk);
        #1;
        check_all("async.load", 32'h0000_3000, 1'b1);

        // Randomized traffic against a behavioural model.
        m_pc    = 32'h0000_3000;
        m_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic st;
            st = ($urandom_range(0, 7) != 0);
            r  = $urandom;
            if ($urandom_range(0, 3) == 0) r = m_pc + 32'd4;
            step(st, r);
            if (st) begin
                m_pc    = r;
                m_valid = 1'b1;
            end else begin
                m_pc    = 32'h0000_0000;
                m_valid = 1'b0;
            end
            check_all($sformatf("rnd%0d", k), m_pc, m_valid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
